// File: rtl/demux4_2.sv
// rtl/demux4_2.sv - registered 1-to-4 router with a one-entry valid/ready slot per sink
// Optional broadcast to all four sinks: define DEMUX4_2_BCAST_EN.
module demux4_2 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_sel,
  input  logic             in_valid,
`ifdef DEMUX4_2_BCAST_EN
  input  logic             in_bcast,
`endif
  output logic             in_ready,
  output logic [WIDTH-1:0] output_data,
  output logic [WIDTH-1:0] alu_data,
  output logic [WIDTH-1:0] bstack_data,
  output logic [WIDTH-1:0] bstored_data,
  output logic             output_valid,
  output logic             alu_valid,
  output logic             bstack_valid,
  output logic             bstored_valid,
  input  logic             output_ready,
  input  logic             alu_ready,
  input  logic             bstack_ready,
  input  logic             bstored_ready
);

  // Slot index equals the in_sel code: 3 output, 2 alu, 1 bstack, 0 bstored.
  logic [WIDTH-1:0] data_q [4];
  logic [WIDTH-1:0] data_d [4];
  logic [3:0]       valid_q;
  logic [3:0]       valid_d;
  logic [3:0]       sink_ready;
  logic [3:0]       slot_free;
  logic [3:0]       load;
  logic             bcast;
  logic             accept;

`ifdef DEMUX4_2_BCAST_EN
  assign bcast = in_bcast;
`else
  assign bcast = 1'b0;
`endif

  assign sink_ready = {output_ready, alu_ready, bstack_ready, bstored_ready};

  // A slot can take a word if empty or draining on this same edge.
  assign slot_free = ~valid_q | sink_ready;
  assign in_ready  = bcast ? (&slot_free) : slot_free[in_sel];
  assign accept    = in_valid & in_ready;

  always_comb begin
    load = 4'b0000;
    if (accept) begin
      load = bcast ? 4'b1111 : (4'b0001 << in_sel);
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      valid_d[i] = load[i] | (valid_q[i] & ~sink_ready[i]);
      data_d[i]  = load[i] ? in_data : data_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 4'b0000;
      for (int i = 0; i < 4; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      for (int i = 0; i < 4; i++) begin
        data_q[i] <= data_d[i];
      end
    end
  end

  assign output_data   = data_q[3];
  assign alu_data      = data_q[2];
  assign bstack_data   = data_q[1];
  assign bstored_data  = data_q[0];
  assign output_valid  = valid_q[3];
  assign alu_valid     = valid_q[2];
  assign bstack_valid  = valid_q[1];
  assign bstored_valid = valid_q[0];

endmodule

// File: tb/tb_demux4_2.sv
// tb/tb_demux4_2.sv - directed self-checking bench for demux4_2
module tb_demux4_2;
  logic        clk;
  logic        rst;
  logic [15:0] in_data;
  logic [1:0]  in_sel;
  logic        in_valid;
  logic        in_bcast;
  logic        in_ready;
  logic [15:0] output_data, alu_data, bstack_data, bstored_data;
  logic        output_valid, alu_valid, bstack_valid, bstored_valid;
  logic        output_ready, alu_ready, bstack_ready, bstored_ready;

  int tests;
  int fails;

  demux4_2 #(.WIDTH(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_data       (in_data),
    .in_sel        (in_sel),
    .in_valid      (in_valid),
`ifdef DEMUX4_2_BCAST_EN
    .in_bcast      (in_bcast),
`endif
    .in_ready      (in_ready),
    .output_data   (output_data),
    .alu_data      (alu_data),
    .bstack_data   (bstack_data),
    .bstored_data  (bstored_data),
    .output_valid  (output_valid),
    .alu_valid     (alu_valid),
    .bstack_valid  (bstack_valid),
    .bstored_valid (bstored_valid),
    .output_ready  (output_ready),
    .alu_ready     (alu_ready),
    .bstack_ready  (bstack_ready),
    .bstored_ready (bstored_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] valids();
    return {output_valid, alu_valid, bstack_valid, bstored_valid};
  endfunction

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    in_data = '0; in_sel = 2'b00; in_valid = 1'b0; in_bcast = 1'b0;
    output_ready = 1'b0; alu_ready = 1'b0; bstack_ready = 1'b0; bstored_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();

    // Reset / idle state
    chk("reset_valids", {28'd0, valids()}, 32'h0);
    chk("reset_data_out_alu", {output_data, alu_data}, 32'h0);
    chk("reset_data_bs_bst", {bstack_data, bstored_data}, 32'h0);
    for (int s = 0; s < 4; s++) begin
      in_sel = s[1:0];
      #1;
      chk($sformatf("idle_in_ready_sel%0d", s), {31'd0, in_ready}, 32'h1);
    end
    in_sel = 2'b10;
    tick();
    in_sel = 2'b01;
    tick();
    chk("sel_change_no_valid", {28'd0, valids()}, 32'h0);

    // Single word to ALU
    alu_ready = 1'b1;
    in_data = 16'hA5A5; in_sel = 2'b10; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("alu_data", {16'd0, alu_data}, 32'h0000A5A5);
    chk("alu_only_valid", {28'd0, valids()}, 32'h4);
    tick();
    chk("alu_drained", {28'd0, valids()}, 32'h0);

    // Stalled bstack with traffic to another sink
    in_data = 16'h1234; in_sel = 2'b01; in_valid = 1'b1;
    #1;
    chk("bstack_first_ready", {31'd0, in_ready}, 32'h1);
    tick();
    in_data = 16'h5678;
    #1;
    chk("bstack_stall_ready", {31'd0, in_ready}, 32'h0);
    chk("bstack_hold_data0", {16'd0, bstack_data}, 32'h00001234);
    tick();
    chk("bstack_hold_data1", {16'd0, bstack_data}, 32'h00001234);
    chk("bstack_hold_valid", {31'd0, bstack_valid}, 32'h1);
    in_data = 16'h9999; in_sel = 2'b11;
    #1;
    chk("output_ready_while_bs_stall", {31'd0, in_ready}, 32'h1);
    tick();
    chk("output_data", {16'd0, output_data}, 32'h00009999);
    chk("valids_out_bs", {28'd0, valids()}, 32'hA);
    in_data = 16'h5678; in_sel = 2'b01;
    #1;
    chk("bstack_still_blocked", {31'd0, in_ready}, 32'h0);
    bstack_ready = 1'b1;
    #1;
    chk("bstack_drain_ready", {31'd0, in_ready}, 32'h1);
    tick();
    in_valid = 1'b0;
    chk("bstack_replaced_data", {16'd0, bstack_data}, 32'h00005678);
    chk("bstack_replaced_valid", {31'd0, bstack_valid}, 32'h1);
    tick();
    chk("bstack_drained", {31'd0, bstack_valid}, 32'h0);
    chk("output_held", {15'd0, output_valid, output_data}, 32'h00019999);
    output_ready = 1'b1;
    tick();
    chk("all_empty", {28'd0, valids()}, 32'h0);

    // Back-to-back stream to bstored
    bstored_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_data = i[15:0]; in_sel = 2'b00; in_valid = 1'b1;
      #1;
      chk($sformatf("stream_ready_%0d", i), {31'd0, in_ready}, 32'h1);
      tick();
      chk($sformatf("stream_word_%0d", i), {15'd0, bstored_valid, bstored_data}, 32'h10000 | i);
    end
    in_valid = 1'b0;
    tick();
    chk("stream_end", {31'd0, bstored_valid}, 32'h0);

    // Reset drops a held word
    bstored_ready = 1'b0;
    in_data = 16'h00FF; in_sel = 2'b00; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("bstored_full", {15'd0, bstored_valid, bstored_data}, 32'h000100FF);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("reset_drop", {15'd0, bstored_valid, bstored_data}, 32'h0);
    bstored_ready = 1'b1;
    tick();
    chk("reset_drop_stays", {15'd0, bstored_valid, bstored_data}, 32'h0);

`ifdef DEMUX4_2_BCAST_EN
    // Broadcast waits for every slot
    output_ready = 1'b0; alu_ready = 1'b0; bstack_ready = 1'b0; bstored_ready = 1'b0;
    in_data = 16'h1111; in_sel = 2'b10; in_valid = 1'b1;
    tick();
    in_bcast = 1'b1; in_data = 16'hBEEF; in_sel = 2'b00;
    #1;
    chk("bcast_blocked", {31'd0, in_ready}, 32'h0);
    alu_ready = 1'b1;
    #1;
    chk("bcast_ready", {31'd0, in_ready}, 32'h1);
    tick();
    in_valid = 1'b0; in_bcast = 1'b0; alu_ready = 1'b0;
    chk("bcast_valids", {28'd0, valids()}, 32'hF);
    chk("bcast_data_out_alu", {output_data, alu_data}, 32'hBEEFBEEF);
    chk("bcast_data_bs_bst", {bstack_data, bstored_data}, 32'hBEEFBEEF);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/demux4_2.md
Name: demux4_2

Overview:
- Registered 1-to-4 data router for the stack datapath; the write-side counterpart of the 4:1 source-select mux.
- Takes one word per handshake and steers it by a 2-bit select to one of four sinks: output port, ALU operand, B-stack push, B-stored register.
- Each sink has its own one-entry output register with valid/ready, so a stalled sink never blocks traffic to the other sinks.

Parameters:
- WIDTH, 16, data word width.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  WIDTH  word to route.
- in_sel  input  2  destination: 11 output, 10 alu, 01 bstack, 00 bstored.
- in_valid  input  1  in_data/in_sel valid.
- in_ready  output  1  word accepted on this edge when in_valid & in_ready.
- output_data, alu_data, bstack_data, bstored_data  output  WIDTH each  per-sink registered data.
- output_valid, alu_valid, bstack_valid, bstored_valid  output  1 each  per-sink data valid.
- output_ready, alu_ready, bstack_ready, bstored_ready  input  1 each  sink accepts on this edge when valid & ready.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: all four *_valid = 0, all four *_data = 0.
- Reset is applied regardless of in_valid or sink ready. Held words are dropped, not delivered.
- Per-sink slot state:
  - EMPTY (valid=0) -> FULL on accept with matching sel.
  - FULL -> EMPTY on sink handshake with no new accept to that sink.
  - FULL -> FULL with new data when the sink handshake and a new accept for that sink occur in the same cycle.
- in_ready is combinational: selected slot is EMPTY, or its sink ready is high in this cycle.
  - It depends only on in_sel and the selected slot, not on in_valid.
- Latency: accepted word appears on the selected sink's *_data with *_valid=1 on the next cycle (1-cycle latency). Throughput is 1 word/cycle per sink when the sink ready is held high.
- Hold rule: while *_valid=1 and *_ready=0, *_data and *_valid stay stable.
- Non-selected slots are never modified by an accept.
- Data is passed unmodified, full WIDTH, with no arithmetic.
- A sink's ready while its valid=0 has no effect.
- in_sel changing while in_valid=0 has no effect.
- Only one slot is written per accepted word, except in broadcast mode.

Optional Feature:
- Macro: DEMUX4_2_BCAST_EN.
- Enabled:
  - Adds input port in_bcast (1 bit).
  - When in_valid & in_bcast, in_sel is ignored. in_ready = all four slots (EMPTY or sink ready).
  - On accept, in_data is loaded into all four slots and all four valids set the next cycle.
  - Each sink then drains independently.
- Disabled: no in_bcast port; routing is strictly by in_sel.

Test Plan:
- Reset then idle -> all *_valid=0, all *_data=0x0000, in_ready=1 for every in_sel.
- in_data=0xA5A5, in_sel=10, in_valid=1 for one cycle, alu_ready=1 -> next cycle alu_data=0xA5A5, alu_valid=1 for one cycle; other valids stay 0.
- bstack_ready=0. Send 0x1234 with sel=01, then 0x5678 with sel=01 -> second word sees in_ready=0, bstack_data holds 0x1234.
  - Meanwhile send 0x9999 with sel=11 -> accepted, output_data=0x9999 next cycle.
  - Raise bstack_ready -> 0x1234 drained and 0x5678 accepted in the same cycle; bstack_valid stays 1 with 0x5678.
- Back-to-back stream 0x0001..0x0008 to sel=00 with bstored_ready=1 -> eight consecutive cycles of bstored_valid=1 with data in order, no bubbles.
- bstored slot FULL with 0x00FF and ready=0, assert rst for one cycle -> bstored_valid=0 and bstored_data=0x0000 after the edge; word 0x00FF never handshakes.
- DEMUX4_2_BCAST_EN, in_bcast=1, in_data=0xBEEF, alu slot full and alu_ready=0 -> in_ready=0.
  - Then alu_ready=1 -> accepted; all four *_data=0xBEEF with valid=1 next cycle.
